// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round constants, S-box and the byte/word
// helpers used by the round logic and the on-the-fly key schedule.
package aes_pkg;

    localparam int BLK_W = 128;
    localparam int NR    = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Element 0 sits in bits [127:120], so a plain 128-bit vector maps onto
    // FIPS-197 byte order (byte i = row i%4, column i/4) without reshuffling.
    typedef logic [0:15][7:0] state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    localparam logic [0:9][7:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic state_t to_state(input logic [BLK_W-1:0] v);
        return state_t'(v);
    endfunction

    function automatic logic [BLK_W-1:0] from_state(input state_t s);
        return s;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Column bytes a0..a3 are packed MSB-first (a0 in [31:24]).
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // One step of the AES-128 key expansion: four words in, next four out.
    function automatic logic [BLK_W-1:0] next_round_key(input logic [BLK_W-1:0] k,
                                                         input logic [7:0]       rcon);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns and
// AddRoundKey. MixColumns is bypassed when last_round_i is set.
module aes_round_comb
    import aes_pkg::*;
(
    input  state_t           state_i,
    input  logic [BLK_W-1:0] rkey_i,
    input  logic             last_round_i,
    output state_t           state_o
);

    logic [7:0]  sr_byte [16];
    logic [31:0] col_out [4];

    // Output byte (row r, col c) takes the S-box of input (row r, col c+r).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = R + 4 * ((C + R) % 4);
            assign sr_byte[gi] = sbox(state_i[SRC]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [31:0] sr_col;
            logic [31:0] mc_col;
            assign sr_col = {sr_byte[4*gi], sr_byte[4*gi+1], sr_byte[4*gi+2], sr_byte[4*gi+3]};
            assign mc_col = mix_column(sr_col);
            assign col_out[gi] = (last_round_i ? sr_col : mc_col)
                                 ^ rkey_i[BLK_W-1-32*gi -: 32];
        end
    endgenerate

    assign state_o = to_state({col_out[0], col_out[1], col_out[2], col_out[3]});

endmodule

// File: rtl/ofb_enc.sv
// AES-128 OFB block: one round per clock, keystream on pre_enc_res and
// keystream XOR image on ciphertext. Macro OFB_AUTO_CHAIN_EN adds iv_load.
module ofb_enc
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef OFB_AUTO_CHAIN_EN
    input  logic             iv_load,
`endif
    input  logic [BLK_W-1:0] image,
    input  logic [BLK_W-1:0] key,
    input  logic [BLK_W-1:0] iv,
    output logic [BLK_W-1:0] ciphertext,
    output logic [BLK_W-1:0] pre_enc_res,
    output logic             busy,
    output logic             done
);

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       round_q, round_d;
    state_t           blk_q, blk_d;
    logic [BLK_W-1:0] rkey_q, rkey_d;
    logic [BLK_W-1:0] image_q, image_d;
    logic [BLK_W-1:0] ct_q, ct_d;
    logic [BLK_W-1:0] pre_q, pre_d;
    logic             done_q, done_d;

    logic [3:0]       rcon_idx;
    logic [BLK_W-1:0] rkey_next;
    logic [BLK_W-1:0] iv_sel;
    logic             last_round;
    state_t           blk_next;

`ifdef OFB_AUTO_CHAIN_EN
    // The last keystream block doubles as the feedback register.
    assign iv_sel = iv_load ? iv : pre_q;
`else
    assign iv_sel = iv;
`endif

    // rkey_q holds the key of the previous round; the next one is derived here.
    assign rcon_idx   = round_q - 4'd1;
    assign rkey_next  = next_round_key(rkey_q, RCON[rcon_idx]);
    assign last_round = (round_q == LAST_ROUND);

    aes_round_comb u_round (
        .state_i      (blk_q),
        .rkey_i       (rkey_next),
        .last_round_i (last_round),
        .state_o      (blk_next)
    );

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        rkey_d  = rkey_q;
        image_d = image_q;
        ct_d    = ct_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    image_d = image;
                    rkey_d  = key;
                    blk_d   = to_state(iv_sel ^ key);
                    round_d = 4'd1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d   = blk_next;
                rkey_d  = rkey_next;
                round_d = round_q + 4'd1;
                if (last_round) begin
                    pre_d   = from_state(blk_next);
                    ct_d    = from_state(blk_next) ^ image_q;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            rkey_q  <= '0;
            image_q <= '0;
            ct_q    <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            rkey_q  <= rkey_d;
            image_q <= image_d;
            ct_q    <= ct_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    assign ciphertext  = ct_q;
    assign pre_enc_res = pre_q;
    assign busy        = (fsm_q == ST_RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_ofb_enc.sv
// Bench for ofb_enc: known-answer table, busy/reset corner sequences and
// random blocks checked against a behavioural AES model.
module tb_ofb_enc;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] image, key, iv;
    logic [127:0] ciphertext, pre_enc_res;
    logic         busy, done;
`ifdef OFB_AUTO_CHAIN_EN
    logic         iv_load;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    ofb_enc dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef OFB_AUTO_CHAIN_EN
        .iv_load     (iv_load),
`endif
        .image       (image),
        .key         (key),
        .iv          (iv),
        .ciphertext  (ciphertext),
        .pre_enc_res (pre_enc_res),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- behavioural reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    tmp[rw + 4*c] = sbox_m[st[rw + 4*((c + rw) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    st[4*c]   = gmul(tmp[4*c], 8'h02) ^ gmul(tmp[4*c+1], 8'h03) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 8'h02) ^ gmul(tmp[4*c+2], 8'h03) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 8'h02) ^ gmul(tmp[4*c+3], 8'h03);
                    st[4*c+3] = gmul(tmp[4*c], 8'h03) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 8'h02);
                end else begin
                    for (int rw = 0; rw < 4; rw++) st[4*c+rw] = tmp[4*c+rw];
                end
                for (int rw = 0; rw < 4; rw++) st[4*c+rw] = st[4*c+rw] ^ w[4*r+c][31-8*rw -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_block(input logic [127:0] k, input logic [127:0] v, input logic [127:0] m);
        key   = k;
        iv    = v;
        image = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
        chk("done_low_after_start", {127'd0, done}, 128'd0);
    endtask

    task automatic wait_done(input bit noise, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (noise) begin
                key   = rnd128();
                iv    = rnd128();
                image = rnd128();
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=no_done expected=done_within_30_cycles");
        end
    endtask

    task automatic run_block(input logic [127:0] k, input logic [127:0] v, input logic [127:0] m,
                             input bit noise, output logic [127:0] pre, output logic [127:0] ct,
                             output int lat);
        start_block(k, v, m);
        wait_done(noise, lat);
        pre = pre_enc_res;
        ct  = ciphertext;
        $display("txn key=%h iv=%h img=%h pre=%h ct=%h lat=%0d", k, v, m, pre, ct, lat);
    endtask

    task automatic watch_idle(input string name, input int cycles);
        int pulses;
        int busy_hi;
        pulses  = 0;
        busy_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
            if (busy === 1'b1) busy_hi++;
        end
        chk({name, "_done_pulses"}, 128'(pulses), 128'd0);
        chk({name, "_busy_cycles"}, 128'(busy_hi), 128'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] k;
        logic [127:0] v;
        logic [127:0] m;
        logic [127:0] exp_pre;
        logic [127:0] exp_ct;
    } kat_t;

    kat_t kat [3];

    localparam logic [127:0] SP_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SP_P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] SP_O1   = 128'h50fe67cc996d32b6da0937e99bafec60;
    localparam logic [127:0] SP_C1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] SP_O2   = 128'hd9a4dada0892239f6b8b3d7680e15674;
    localparam logic [127:0] SP_C2   = 128'h7789508d16918f03f53c52dac54ed825;
    localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] got_pre, got_ct, prev_pre, k, v, m, exp_pre;
        int lat;

        kat[0] = '{"fips197", FIPS_K, FIPS_P, 128'd0, FIPS_C, FIPS_C};
        kat[1] = '{"sp_blk1", SP_KEY, SP_IV, SP_P1, SP_O1, SP_C1};
        kat[2] = '{"sp_blk2", SP_KEY, SP_O1, SP_P2, SP_O2, SP_C2};

        build_sbox();
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        iv    = '0;
        image = '0;
`ifdef OFB_AUTO_CHAIN_EN
        iv_load = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ct", ciphertext, 128'd0);
        chk("reset_pre", pre_enc_res, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);

        // Known answers, issued back-to-back so block 2 starts in the done cycle.
        for (int i = 0; i < 3; i++) begin
            run_block(kat[i].k, kat[i].v, kat[i].m, 1'b0, got_pre, got_ct, lat);
            chk({kat[i].name, "_pre"}, got_pre, kat[i].exp_pre);
            chk({kat[i].name, "_ct"}, got_ct, kat[i].exp_ct);
            chk({kat[i].name, "_latency"}, 128'(lat), 128'd10);
        end

        // Busy protection: perturb every input and pulse start during round 5.
        start_block(SP_KEY, SP_IV, SP_P1);
        repeat (4) @(posedge clk);
        #1;
        key   = rnd128();
        iv    = rnd128();
        image = rnd128();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat);
        $display("txn busy_protect pre=%h ct=%h lat=%0d", pre_enc_res, ciphertext, lat);
        chk("busyprot_latency", 128'(lat), 128'd5);
        chk("busyprot_pre", pre_enc_res, SP_O1);
        chk("busyprot_ct", ciphertext, SP_C1);
        watch_idle("busyprot", 15);

        // Reset at round 4 aborts the block.
        start_block(FIPS_K, FIPS_P, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn midreset pre=%h ct=%h busy=%0b done=%0b", pre_enc_res, ciphertext, busy, done);
        chk("midrst_ct", ciphertext, 128'd0);
        chk("midrst_pre", pre_enc_res, 128'd0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_done", {127'd0, done}, 128'd0);
        watch_idle("midrst", 15);
        run_block(SP_KEY, SP_IV, SP_P1, 1'b0, got_pre, got_ct, lat);
        chk("after_rst_pre", got_pre, SP_O1);
        chk("after_rst_ct", got_ct, SP_C1);

        // Random blocks with input noise while busy, half of them chained.
        prev_pre = got_pre;
        for (int i = 0; i < 24; i++) begin
            k = rnd128();
            v = ($urandom_range(0, 1) == 1) ? prev_pre : rnd128();
            m = rnd128();
            exp_pre = aes_model(k, v);
            run_block(k, v, m, 1'b1, got_pre, got_ct, lat);
            chk("rand_pre", got_pre, exp_pre);
            chk("rand_ct", got_ct, exp_pre ^ m);
            chk("rand_latency", 128'(lat), 128'd10);
            prev_pre = got_pre;
        end

`ifdef OFB_AUTO_CHAIN_EN
        // Internal feedback: zero after reset, then last pre_enc_res.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv_load = 1'b0;
        run_block(SP_KEY, rnd128(), SP_P1, 1'b0, got_pre, got_ct, lat);
        chk("auto_zero_fb_ct", got_ct, aes_model(SP_KEY, 128'd0) ^ SP_P1);
        iv_load = 1'b1;
        run_block(SP_KEY, SP_IV, SP_P1, 1'b0, got_pre, got_ct, lat);
        chk("auto_blk1_ct", got_ct, SP_C1);
        iv_load = 1'b0;
        run_block(SP_KEY, rnd128(), SP_P2, 1'b0, got_pre, got_ct, lat);
        chk("auto_blk2_ct", got_ct, SP_C2);
        chk("auto_blk2_pre", got_pre, SP_O2);
        iv_load = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
